pixel_capture_engine: RTL and testbench

Parametrised successor to the camera pixel input path. Samples camera pclk/hsync/vsync/data in the system clock domain and packs bytes into SRAM-width words through a small word FIFO. Writes each word to SRAM via the start/ready mux handshake. Supports JPEG (FFD9-terminated) and raw (vsync-terminated) frames, single-shot arming, and typed sticky errors. Sits between the camera pins and the SRAM mux; stop_addr feeds the SPI controller.

---
 rtl/pixel_capture_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_pixel_capture_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_capture_engine.sv
// rtl/pixel_capture_engine.sv - camera byte capture packed into SRAM words; `define FRAME_CRC_EN adds frame_crc
module pixel_capture_engine #(
    parameter int   DATA_W       = 8,
    parameter int   SRAM_DW      = 16,
    parameter int   ADDR_W       = 16,
    parameter int   BASE_ADDR    = 0,
    parameter int   MAX_WORDS    = 65535,
    parameter int   FIFO_DEPTH   = 8,
    parameter logic VSYNC_ACTIVE = 1'b0,
    parameter int   JPEG_MODE    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               capture_req,
    input  logic               camera_vsync,
    input  logic               camera_hsync,
    input  logic               camera_pclk,
    input  logic [DATA_W-1:0]  camera_data,
    output logic               sram_start,
    output logic               sram_rw,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [SRAM_DW-1:0] sram_data,
    input  logic               sram_ready,
    output logic               busy,
    output logic               frame_end,
    output logic               error,
    output logic [1:0]         error_code,
    output logic [ADDR_W-1:0]  stop_addr
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0]        frame_crc
`endif
);

    localparam int LANES = SRAM_DW / DATA_W;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FAW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [DATA_W-1:0] BYTE_FF = DATA_W'(8'hFF);
    localparam logic [DATA_W-1:0] BYTE_D9 = DATA_W'(8'hD9);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_VS    = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_CAPTURE    = 3'd3;
    localparam logic [2:0] S_FLUSH      = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_ERR        = 3'd6;

    logic [2:0]         state;
    logic [DATA_W-1:0]  data_s1, data_s2;
    logic               vsync_s1, vsync_s2, hsync_s1, hsync_s2, pclk_s1, pclk_s2, pclk_d;
    logic               vs_active, pclk_edge, byte_acc, jpeg_end, raw_end;
    logic [LW-1:0]      lane_cnt;
    logic               lane_last;
    logic [SRAM_DW-1:0] pack_buf, pack_next, push_word;
    logic               prev_ff;
    logic               push_req, push_ok, overflow, max_hit, pop;
    logic [31:0]        push_cnt;
    logic [ADDR_W-1:0]  wr_idx;
    logic [SRAM_DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]     wr_ptr, rd_ptr;
    logic [FAW:0]       fifo_cnt;
    logic               fifo_full;
    logic               out_busy, out_low, wr_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_s1  <= '0;
            data_s2  <= '0;
            vsync_s1 <= 1'b0;
            vsync_s2 <= 1'b0;
            hsync_s1 <= 1'b0;
            hsync_s2 <= 1'b0;
            pclk_s1  <= 1'b0;
            pclk_s2  <= 1'b0;
            pclk_d   <= 1'b0;
        end else begin
            data_s1  <= camera_data;
            data_s2  <= data_s1;
            vsync_s1 <= camera_vsync;
            vsync_s2 <= vsync_s1;
            hsync_s1 <= camera_hsync;
            hsync_s2 <= hsync_s1;
            pclk_s1  <= camera_pclk;
            pclk_s2  <= pclk_s1;
            pclk_d   <= pclk_s2;
        end
    end

    assign vs_active = (vsync_s2 == VSYNC_ACTIVE);
    assign pclk_edge = pclk_s2 & ~pclk_d;
    assign byte_acc  = (state == S_CAPTURE) && pclk_edge && hsync_s2 && !vs_active;
    assign jpeg_end  = (JPEG_MODE != 0) && byte_acc && prev_ff && (data_s2 == BYTE_D9);
    assign raw_end   = (JPEG_MODE == 0) && vs_active;
    assign lane_last = (lane_cnt == LW'(LANES - 1));

    always_comb begin
        pack_next = pack_buf;
        pack_next[lane_cnt*DATA_W +: DATA_W] = data_s2;
    end

    // Partial words leave FLUSH with upper lanes still zero from the last clear
    always_comb begin
        push_req  = 1'b0;
        push_word = pack_next;
        if (byte_acc && lane_last) begin
            push_req = 1'b1;
        end else if (state == S_FLUSH && lane_cnt != '0) begin
            push_req  = 1'b1;
            push_word = pack_buf;
        end
    end

    assign wr_done   = out_busy && out_low && sram_ready;
    assign pop       = wr_done;
    assign fifo_full = (fifo_cnt == (FAW+1)'(FIFO_DEPTH));
    assign overflow  = push_req && fifo_full && !pop;
    assign max_hit   = push_req && (push_cnt >= 32'(MAX_WORDS));
    assign push_ok   = push_req && !overflow && !max_hit;

    assign sram_start = !reset && (fifo_cnt != '0) && sram_ready && !out_busy && (state != S_ERR);
    assign sram_rw    = 1'b0;
    assign sram_addr  = (sram_start || out_busy) ? (ADDR_W'(BASE_ADDR) + wr_idx) : '0;
    assign sram_data  = (sram_start || out_busy) ? fifo_mem[rd_ptr] : '0;
    assign busy       = (state == S_WAIT_VS) || (state == S_WAIT_START) ||
                        (state == S_CAPTURE) || (state == S_FLUSH);
    assign frame_end  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            error      <= 1'b0;
            error_code <= 2'd0;
            stop_addr  <= '0;
            lane_cnt   <= '0;
            pack_buf   <= '0;
            prev_ff    <= 1'b0;
            push_cnt   <= '0;
            wr_idx     <= '0;
        end else begin
            if (push_ok) push_cnt <= push_cnt + 32'd1;
            if (pop)     wr_idx   <= wr_idx + 1'b1;
            case (state)
                S_IDLE: if (capture_req) begin
                    state      <= S_WAIT_VS;
                    error      <= 1'b0;
                    error_code <= 2'd0;
                    lane_cnt   <= '0;
                    pack_buf   <= '0;
                    prev_ff    <= 1'b0;
                    push_cnt   <= '0;
                    wr_idx     <= '0;
                end
                S_WAIT_VS:    if (vs_active)  state <= S_WAIT_START;
                S_WAIT_START: if (!vs_active) state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (JPEG_MODE != 0 && vs_active) begin
                        state      <= S_ERR;
                        error      <= 1'b1;
                        error_code <= 2'd1;
                    end else if (overflow) begin
                        state      <= S_ERR;
                        error      <= 1'b1;
                        error_code <= 2'd2;
                    end else if (max_hit) begin
                        state      <= S_ERR;
                        error      <= 1'b1;
                        error_code <= 2'd3;
                    end else begin
                        if (byte_acc) begin
                            prev_ff <= (data_s2 == BYTE_FF);
                            if (lane_last) begin
                                lane_cnt <= '0;
                                pack_buf <= '0;
                            end else begin
                                lane_cnt <= lane_cnt + 1'b1;
                                pack_buf <= pack_next;
                            end
                        end
                        if (jpeg_end || raw_end) state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (overflow) begin
                        state      <= S_ERR;
                        error      <= 1'b1;
                        error_code <= 2'd2;
                    end else if (max_hit) begin
                        state      <= S_ERR;
                        error      <= 1'b1;
                        error_code <= 2'd3;
                    end else if (push_req) begin
                        lane_cnt <= '0;
                        pack_buf <= '0;
                    end else if (fifo_cnt == '0 && !out_busy) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    stop_addr <= wr_idx;
                    state     <= S_IDLE;
                end
                S_ERR:   if (!out_busy) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_word;
    end

    // An in-flight write cannot be aborted, so the discard waits for it to finish
    always_ff @(posedge clk) begin
        if (reset || (state == S_ERR && !out_busy)) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_busy <= 1'b0;
            out_low  <= 1'b0;
        end else if (sram_start) begin
            out_busy <= 1'b1;
            out_low  <= 1'b0;
        end else if (out_busy) begin
            if (!sram_ready) begin
                out_low <= 1'b1;
            end else if (out_low) begin
                out_busy <= 1'b0;
                out_low  <= 1'b0;
            end
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] crc_run;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [DATA_W-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_run   <= '0;
            frame_crc <= '0;
        end else begin
            if (state == S_IDLE && capture_req) begin
                crc_run <= 16'hFFFF;
            end else if (byte_acc && !overflow && !max_hit) begin
                crc_run <= crc16_step(crc_run, data_s2);
            end
            if (state == S_DONE) frame_crc <= crc_run;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_capture_engine.sv
// tb/tb_pixel_capture_engine.sv - scoreboard bench for pixel_capture_engine
module tb_pixel_capture_engine;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, capture_req, capture_req_mw;
    logic        camera_vsync, camera_hsync, camera_pclk;
    logic [7:0]  camera_data;
    logic        sram_start, sram_rw, sram_ready, busy, frame_end, error;
    logic [15:0] sram_addr, sram_data, stop_addr;
    logic [1:0]  error_code;
    logic        sram_start_mw, sram_rw_mw, sram_ready_mw, busy_mw, frame_end_mw, error_mw;
    logic [15:0] sram_addr_mw, sram_data_mw, stop_addr_mw;
    logic [1:0]  error_code_mw;
`ifdef FRAME_CRC_EN
    logic [15:0] frame_crc, frame_crc_mw;
`endif

    pixel_capture_engine dut (
        .clk(clk), .reset(reset), .capture_req(capture_req),
        .camera_vsync(camera_vsync), .camera_hsync(camera_hsync),
        .camera_pclk(camera_pclk), .camera_data(camera_data),
        .sram_start(sram_start), .sram_rw(sram_rw), .sram_addr(sram_addr),
        .sram_data(sram_data), .sram_ready(sram_ready), .busy(busy),
        .frame_end(frame_end), .error(error), .error_code(error_code),
        .stop_addr(stop_addr)
`ifdef FRAME_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    pixel_capture_engine #(.MAX_WORDS(2)) dut_mw (
        .clk(clk), .reset(reset), .capture_req(capture_req_mw),
        .camera_vsync(camera_vsync), .camera_hsync(camera_hsync),
        .camera_pclk(camera_pclk), .camera_data(camera_data),
        .sram_start(sram_start_mw), .sram_rw(sram_rw_mw), .sram_addr(sram_addr_mw),
        .sram_data(sram_data_mw), .sram_ready(sram_ready_mw), .busy(busy_mw),
        .frame_end(frame_end_mw), .error(error_mw), .error_code(error_code_mw),
        .stop_addr(stop_addr_mw)
`ifdef FRAME_CRC_EN
        , .frame_crc(frame_crc_mw)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          fe_cnt = 0;
    logic        hold = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_mw_q[$];
    logic [7:0]  crc_bytes[$];
    logic        mdl_en;
    logic [15:0] mdl_buf, mdl_idx;
    int          mdl_lane;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mdl_reset();
        mdl_buf  = '0;
        mdl_idx  = '0;
        mdl_lane = 0;
        crc_bytes.delete();
    endtask

    // Expected words are queued before the pclk edge so they precede the DUT write
    task automatic send_byte(input logic [7:0] b, input bit last);
        if (mdl_en) begin
            crc_bytes.push_back(b);
            mdl_buf[mdl_lane*8 +: 8] = b;
            mdl_lane++;
            if (mdl_lane == 2 || last) begin
                exp_q.push_back({mdl_idx, mdl_buf});
                mdl_idx  = mdl_idx + 16'd1;
                mdl_buf  = '0;
                mdl_lane = 0;
            end
        end
        camera_data = b;
        camera_pclk = 1'b0;
        tick(6);
        camera_pclk = 1'b1;
        tick(6);
    endtask

    task automatic vsync_pulse();
        camera_vsync = 1'b0;
        tick(10);
        camera_vsync = 1'b1;
        tick(10);
    endtask

    task automatic arm();
        capture_req = 1'b1;
        tick(1);
        capture_req = 1'b0;
    endtask

    task automatic wait_fe(input string tag, input int fe0);
        int n = 0;
        while (fe_cnt == fe0 && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, fe_cnt != fe0, 1);
    endtask

    task automatic wait_err(input string tag);
        int n = 0;
        while (!error && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, error, 1);
    endtask

`ifdef FRAME_CRC_EN
    function automatic logic [15:0] ref_crc();
        logic [15:0] c = 16'hFFFF;
        foreach (crc_bytes[i]) begin
            c = c ^ {crc_bytes[i], 8'h00};
            for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    initial begin : frame_end_monitor
        forever begin
            @(negedge clk);
            if (frame_end) fe_cnt++;
        end
    end

    initial begin : sram_main
        int   lat;
        logic saw;
        logic [31:0] e;
        sram_ready = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            saw = sram_start;
            if (saw) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", sram_addr, e[31:16]);
                    check("wr_data", sram_data, e[15:0]);
                end
            end
            @(posedge clk);
            #1;
            if (saw) lat = 3;
            else if (lat > 0) lat--;
            sram_ready = (lat == 0) && !hold;
        end
    end

    initial begin : sram_mw
        int   lat;
        logic saw;
        logic [31:0] e;
        sram_ready_mw = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            saw = sram_start_mw;
            if (saw) begin
                check("mw_write_expected", exp_mw_q.size() != 0, 1);
                if (exp_mw_q.size() != 0) begin
                    e = exp_mw_q.pop_front();
                    check("mw_wr_addr", sram_addr_mw, e[31:16]);
                    check("mw_wr_data", sram_data_mw, e[15:0]);
                end
            end
            @(posedge clk);
            #1;
            if (saw) lat = 3;
            else if (lat > 0) lat--;
            sram_ready_mw = (lat == 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int fe0;
        reset = 1'b1; capture_req = 1'b0; capture_req_mw = 1'b0;
        camera_vsync = 1'b1; camera_hsync = 1'b1; camera_pclk = 1'b0; camera_data = '0;
        mdl_en = 1'b0;
        mdl_reset();
        tick(4);
        check("rst_sram_start", sram_start, 0);
        check("rst_sram_rw", sram_rw, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_data", sram_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_end", frame_end, 0);
        check("rst_error", error, 0);
        check("rst_error_code", error_code, 0);
        check("rst_stop_addr", stop_addr, 0);
        reset = 1'b0;
        tick(3);

        mdl_reset(); mdl_en = 1'b1; fe0 = fe_cnt;
        arm();
        check("t1_busy", busy, 1);
        vsync_pulse();
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'hFF, 0); send_byte(8'hD9, 1);
        wait_fe("t1_frame_end_seen", fe0);
        tick(5);
        check("t1_frame_end_pulses", fe_cnt - fe0, 1);
        check("t1_stop_addr", stop_addr, 3);
        check("t1_error", error, 0);
        check("t1_busy_done", busy, 0);
        check("t1_writes_left", exp_q.size(), 0);

        mdl_reset(); fe0 = fe_cnt;
        arm();
        vsync_pulse();
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        camera_vsync = 1'b0;
        wait_err("t2_error_seen");
        tick(5);
        camera_vsync = 1'b1;
        tick(5);
        check("t2_error_code", error_code, 1);
        check("t2_no_frame_end", fe_cnt, fe0);
        check("t2_stop_addr_kept", stop_addr, 3);
        check("t2_busy", busy, 0);
        check("t2_writes_left", exp_q.size(), 0);

        mdl_en = 1'b0; hold = 1'b1;
        tick(2);
        arm();
        tick(2);
        check("t3_error_cleared", error, 0);
        check("t3_code_cleared", error_code, 0);
        vsync_pulse();
        for (int i = 0; i < 40; i++) send_byte(8'(i + 1), 0);
        check("t3_error", error, 1);
        check("t3_error_code", error_code, 2);
        check("t3_busy", busy, 0);
        hold = 1'b0;
        tick(20);
        check("t3_stop_addr_kept", stop_addr, 3);

        mdl_reset(); mdl_en = 1'b1;
        arm();
        vsync_pulse();
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
        reset = 1'b1;
        tick(1);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_sram_start", sram_start, 0);
        check("t4_rst_stop_addr", stop_addr, 0);
        reset = 1'b0;
        tick(2);
        check("t4_pre_reset_writes", exp_q.size(), 0);
        mdl_reset(); fe0 = fe_cnt;
        arm();
        vsync_pulse();
        send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'hFF, 0); send_byte(8'hD9, 1);
        wait_fe("t4_frame_end_seen", fe0);
        tick(5);
        check("t4_stop_addr", stop_addr, 2);
        check("t4_writes_left", exp_q.size(), 0);

        mdl_en = 1'b0;
        exp_mw_q.push_back({16'd0, 16'h0201});
        exp_mw_q.push_back({16'd1, 16'h0403});
        capture_req_mw = 1'b1;
        tick(1);
        capture_req_mw = 1'b0;
        vsync_pulse();
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
        tick(10);
        check("t5_error", error_mw, 1);
        check("t5_error_code", error_code_mw, 3);
        check("t5_busy", busy_mw, 0);
        check("t5_stop_addr", stop_addr_mw, 0);
        check("t5_writes_left", exp_mw_q.size(), 0);

`ifdef FRAME_CRC_EN
        mdl_reset(); mdl_en = 1'b1; fe0 = fe_cnt;
        arm();
        vsync_pulse();
        for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), 0);
        send_byte(8'hFF, 0); send_byte(8'hD9, 1);
        wait_fe("t6_frame_end_seen", fe0);
        tick(3);
        check("t6_frame_crc", frame_crc, ref_crc());
        check("t6_stop_addr", stop_addr, 5);
        check("t6_writes_left", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
